// File: rtl/shifter_pkg.sv
// Shared encodings for the multi-cycle shifter: operation modes and FSM states.
// Optional rotate support is selected by SHIFTER_ROTATE_EN.
package shifter_pkg;

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;
   localparam logic [1:0] MODE_ROL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/shifter_step.sv
// Combinational one-step shifter: shifts by 0..STEP bits under a mode select.
// Mode 11 rotates left when SHIFTER_ROTATE_EN is defined, otherwise acts as SLL.
module shifter_step
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEP  = 1,
   parameter int unsigned AW    = $clog2(STEP) + 1
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [AW-1:0]    amt_i,
   input  logic [1:0]       mode_i,
   output logic [WIDTH-1:0] data_o
);

   always_comb begin
      data_o = data_i << amt_i;
      case (mode_i)
         MODE_SLL: data_o = data_i << amt_i;
         MODE_SRL: data_o = data_i >> amt_i;
         // Arithmetic shift keeps bit WIDTH-1, which equals the latched sign throughout.
         MODE_SRA: data_o = WIDTH'($signed(data_i) >>> amt_i);
`ifdef SHIFTER_ROTATE_EN
         MODE_ROL: data_o = (data_i << amt_i) | (data_i >> (WIDTH - 32'(amt_i)));
`endif
         default:  data_o = data_i << amt_i;
      endcase
   end

endmodule

// File: rtl/shifter_seq.sv
// Multi-cycle SLL/SRL/SRA(/ROL) unit shifting STEP bits per cycle with start/done handshake.
// Rotate for mode 11 is built only when SHIFTER_ROTATE_EN is defined.
module shifter_seq
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEP  = 1,
   parameter int unsigned SW    = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       mode_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic [SW-1:0]    shamt_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] data_o
);

   localparam int unsigned AW = $clog2(STEP) + 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SW-1:0]    rem_q, rem_d;
   logic [1:0]       mode_q, mode_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [AW-1:0]    amt_c;
   logic [WIDTH-1:0] stepped_c;

   // Per-cycle amount: min(STEP, remaining).
   always_comb begin
      amt_c = AW'(rem_q);
      if ((SW+1)'(rem_q) >= (SW+1)'(STEP)) begin
         amt_c = AW'(STEP);
      end
   end

   shifter_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .AW    (AW)
   ) u_step (
      .data_i (data_q),
      .amt_i  (amt_c),
      .mode_i (mode_q),
      .data_o (stepped_c)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      mode_d  = mode_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               data_d  = data_i;
               mode_d  = mode_i;
               rem_d   = shamt_i;
               state_d = (shamt_i != '0) ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
            data_d = stepped_c;
            rem_d  = SW'((SW+1)'(rem_q) - (SW+1)'(amt_c));
            if (rem_d == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_SHIFT);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         rem_q   <= '0;
         mode_q  <= MODE_SLL;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign data_o = data_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Bench for shifter_seq: STEP=1 and STEP=4 instances driven in parallel, directed table
// plus random ops against an arithmetic reference model (honours SHIFTER_ROTATE_EN).
module tb_shifter_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  mode;
   logic [31:0] din;
   logic [4:0]  sh;
   logic        busy1, done1, busy4, done4;
   logic [31:0] dout1, dout4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   shifter_seq #(.WIDTH(32), .STEP(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .data_i(din),
      .shamt_i(sh), .busy_o(busy1), .done_o(done1), .data_o(dout1));

   shifter_seq #(.WIDTH(32), .STEP(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .data_i(din),
      .shamt_i(sh), .busy_o(busy4), .done_o(done4), .data_o(dout4));

   typedef struct {
      logic [1:0]  m;
      logic [31:0] d;
      int          s;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] d, input int s);
      logic [63:0] t;
      case (m)
         2'b00: return d << s;
         2'b01: return d >> s;
         2'b10: begin
            t = {{32{d[31]}}, d} >> s;
            return t[31:0];
         end
         default: begin
`ifdef SHIFTER_ROTATE_EN
            t = {d, d} << s;
            return t[63:32];
`else
            t = {32'h0, d} << s;
            return t[31:0];
`endif
         end
      endcase
   endfunction

   // One operation on both instances; checks latency, busy length, single done and result.
   task automatic run_op(input logic [1:0] m, input logic [31:0] d, input int s,
                         input bit interfere, input string tag, input logic [31:0] exp);
      int k1, k4, b1, b4, dc1, dc4, dcyc1, dcyc4;
      logic [31:0] r1, r4;
      k1 = s;
      k4 = (s + 3) / 4;
      b1 = 0; b4 = 0; dc1 = 0; dc4 = 0; dcyc1 = -1; dcyc4 = -1;
      r1 = 'x; r4 = 'x;
      @(negedge clk);
      start = 1'b1; mode = m; din = d; sh = 5'(s);
      @(posedge clk);
      for (int c = 1; c <= k1 + 4; c++) begin
         @(negedge clk);
         if (busy1) b1++;
         if (busy4) b4++;
         if (done1) begin dc1++; if (dcyc1 < 0) begin dcyc1 = c; r1 = dout1; end end
         if (done4) begin dc4++; if (dcyc4 < 0) begin dcyc4 = c; r4 = dout4; end end
         if (interfere && c <= 2) begin
            start = 1'b1; mode = 2'b00; din = 32'hFFFF_FFFF; sh = 5'd31;
         end else begin
            start = 1'b0; mode = 2'($urandom); din = $urandom; sh = 5'($urandom);
         end
      end
      check({tag, " busy1"},  32'(b1), 32'(k1));
      check({tag, " busy4"},  32'(b4), 32'(k4));
      check({tag, " dcyc1"},  32'(dcyc1), 32'(k1 + 1));
      check({tag, " dcyc4"},  32'(dcyc4), 32'(k4 + 1));
      check({tag, " ndone1"}, 32'(dc1), 32'd1);
      check({tag, " ndone4"}, 32'(dc4), 32'd1);
      check({tag, " data1"},  r1, exp);
      check({tag, " data4"},  r4, exp);
      check({tag, " hold1"},  dout1, exp);
      check({tag, " hold4"},  dout4, exp);
   endtask

   initial begin
      vec_t vecs[9];
      logic [1:0]  rm;
      logic [31:0] rd;
      int          rs, nd;

      vecs[0] = '{2'b00, 32'h0000_0001, 2,  32'h0000_0004};
      vecs[1] = '{2'b10, 32'h8000_0000, 31, 32'hFFFF_FFFF};
      vecs[2] = '{2'b01, 32'h8000_0000, 31, 32'h0000_0001};
      vecs[3] = '{2'b00, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF};
      vecs[4] = '{2'b01, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF};
      vecs[5] = '{2'b10, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF};
      vecs[6] = '{2'b11, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF};
`ifdef SHIFTER_ROTATE_EN
      vecs[7] = '{2'b11, 32'h8000_0001, 4,  32'h0000_0018};
`else
      vecs[7] = '{2'b11, 32'h8000_0001, 4,  32'h0000_0010};
`endif
      vecs[8] = '{2'b10, 32'h4000_0000, 7,  32'h0080_0000};

      rst = 1'b1; start = 1'b0; mode = 2'b00; din = '0; sh = '0;
      repeat (2) @(negedge clk);
      check("rst busy1", 32'(busy1), 32'd0);
      check("rst done1", 32'(done1), 32'd0);
      check("rst data1", dout1, 32'd0);
      check("rst busy4", 32'(busy4), 32'd0);
      check("rst data4", dout4, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].m, vecs[i].d, vecs[i].s, 1'b0, $sformatf("vec%0d", i), vecs[i].exp);
      end

      // Re-asserted start with different data during SHIFT must be ignored.
      run_op(2'b01, 32'h8000_0000, 4, 1'b1, "restart", 32'h0800_0000);

      // Asynchronous reset in the middle of a shift aborts without done.
      @(negedge clk);
      start = 1'b1; mode = 2'b00; din = 32'h0000_0001; sh = 5'd20;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre-rst busy1", 32'(busy1), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst busy1", 32'(busy1), 32'd0);
      check("arst busy4", 32'(busy4), 32'd0);
      check("arst data1", dout1, 32'd0);
      check("arst data4", dout4, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (done1 || done4) nd++;
      end
      check("arst no done", 32'(nd), 32'd0);
      run_op(2'b00, 32'h0000_0001, 1, 1'b0, "post-rst", 32'h0000_0002);

      for (int i = 0; i < 150; i++) begin
         rm = 2'($urandom);
         rd = $urandom;
         rs = int'($urandom_range(0, 31));
         run_op(rm, rd, rs, 1'b0, $sformatf("rnd%0d", i), model(rm, rd, rs));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shifter_seq.md
# shifter_seq

Parametrised, multi-cycle shift unit that generalises the fixed shift-left-by-two datapath element into a general shifter. It supports logical left, logical right and arithmetic right shifts by a run-time amount, plus optional rotate. It shifts `STEP` bits per cycle under a start/done handshake, so shift amount trades against latency. It sits beside the ALU in the multi-cycle CPU datapath and serves `sll`/`srl`/`sra`-class instructions.

## Interface
- `WIDTH`, default 32: data width. Must be a power of two, ≥ 8.
- `STEP`, default 1: bits shifted per cycle. Must be a power of two, 1..`WIDTH`.
- `SW`, default `$clog2(WIDTH)`: derived shift-amount width. Not to be overridden.
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `start_i` input 1: request. Sampled only in IDLE.
- `mode_i` input 2: operation.
  - 00 = SLL
  - 01 = SRL
  - 10 = SRA
  - 11 = ROL (see Configuration)
- `data_i` input `WIDTH`: operand.
- `shamt_i` input `SW`: shift amount, 0..`WIDTH`-1.
- `busy_o` output 1: high while in SHIFT.
- `done_o` output 1: one-cycle pulse when the result is valid.
- `data_o` output `WIDTH`: result register.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - If `start_i` is high, latch `data_i` into the result register, latch `mode_i`, and set remaining = `shamt_i`.
  - Next state is SHIFT if `shamt_i` ≠ 0, else DONE.
- **SHIFT:** each cycle, shift the result register by n = min(`STEP`, remaining) and subtract n from remaining. When remaining reaches 0, next state is DONE.
- **Fill rules:**
  - SLL: zero-fill LSBs.
  - SRL: zero-fill MSBs.
  - SRA: replicate the latched bit `WIDTH`-1.
  - ROL: bits exiting at the MSB re-enter at the LSB.
- **DONE:** `done_o` = 1 and `data_o` holds the final result. Next state is IDLE unconditionally.
- `start_i` is ignored in SHIFT and DONE. Input changes after acceptance have no effect.
- `data_o` holds its value from DONE until the next accepted start, then tracks the intermediate value.
- **Reset:**
  - State returns to IDLE.
  - `data_o` = 0, `busy_o` = 0, `done_o` = 0, remaining = 0.
  - Reset mid-operation aborts the shift with no `done_o`.

## Timing
- Start is accepted on rising edge E0.
- k = ceil(`shamt_i`/`STEP`) SHIFT cycles follow: `busy_o` is high for exactly k cycles.
- `done_o` is high in the cycle after the last SHIFT cycle, i.e. k+1 cycles after E0.
- `shamt_i` = 0: `done_o` in the cycle immediately after E0, and `data_o` = `data_i`.
- `STEP` = `WIDTH`: k ≤ 1 for every amount, so worst-case latency is 2 cycles.
- Earliest next accept is the edge after DONE, so back-to-back throughput is one op per k+2 cycles.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- `SHIFTER_ROTATE_EN` defined: mode 11 performs rotate-left by `shamt_i`, using the same latency as the other modes.
- Undefined: mode 11 is decoded as SLL and no rotate logic is synthesised.

## Structure
- **Package `shifter_pkg`:**
  - Mode encoding constants: `MODE_SLL`, `MODE_SRL`, `MODE_SRA`, `MODE_ROL`.
  - Typedef for the 3-state FSM encoding.
- **Sub-module `shifter_step`:** combinational, shifts by a variable amount 0..`STEP` under a mode input. It is instantiated once in `shifter_seq`.
- **Top level:** contains the FSM, remaining counter, mode register and result register.

## Test plan
- `WIDTH`=32, `STEP`=1, SLL, 0x00000001, shamt 2:
  - `busy_o` high 2 cycles, `done_o` on cycle 3.
  - `data_o` = 0x00000004.
- `STEP`=4, SRA, 0x80000000, shamt 31:
  - 8 SHIFT cycles.
  - `data_o` = 0xFFFFFFFF. SRL of the same operand gives 0x00000001.
- shamt 0, any mode, 0xDEADBEEF:
  - No `busy_o`.
  - `done_o` the cycle after start, `data_o` = 0xDEADBEEF.
- SRL 0x80000000 shamt 4, with `start_i` re-asserted and `data_i` changed during SHIFT:
  - The second request is ignored.
  - `data_o` = 0x08000000, exactly one `done_o`.
- `rst_i` pulsed during SHIFT:
  - Outputs go to 0 asynchronously and no `done_o` is produced.
  - A subsequent SLL 0x1 by 1 gives 0x00000002.
- Mode 11, 0x80000001, shamt 4:
  - With `SHIFTER_ROTATE_EN`: 0x00000018.
  - Without it: 0x00000010.
